// File: rtl/regfile_test_driver.sv
// Register-file self-test engine: writes two patterns to all 32 registers,
// reads them back on both ports and reports mismatches.
module regfile_test_driver #(
    parameter logic [31:0] SEED         = 32'hA5A5_0000,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] t_data_readRegA,
    input  logic [31:0] t_data_readRegB,
    output logic        test,
    output logic        t_ctrl_writeEnable,
    output logic [4:0]  t_ctrl_writeReg,
    output logic [4:0]  t_ctrl_readRegA,
    output logic [4:0]  t_ctrl_readRegB,
    output logic [31:0] t_data_writeReg,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [4:0]  first_fail_reg,
    output logic        first_fail_port
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t      state_q;
    logic [4:0]  k_q;
    logic        p_q;
    logic        test_q;
    logic        we_q;
    logic [4:0]  wreg_q;
    logic [4:0]  ra_q;
    logic [4:0]  rb_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [7:0]  err_q;
    logic [4:0]  ffreg_q;
    logic        ffport_q;

    // Read data is captured one edge after it is presented and compared the
    // edge after that, so the last read of a pass is checked in DRAIN.
    logic        cmp_v_q;
    logic [4:0]  cidx_q;
    logic [31:0] cap_a_q;
    logic [31:0] cap_b_q;

    logic        cmp_en;
    logic        mis_a;
    logic        mis_b;
    logic [8:0]  err_sum;
    logic [7:0]  err_d;
    logic        go_done;

    function automatic logic [31:0] pat(input logic p, input logic [4:0] i);
        logic [31:0] s;
        s = SEED + {27'd0, i};
        return p ? ~s : s;
    endfunction

    function automatic logic [31:0] exp_val(input logic p, input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : pat(p, i);
    endfunction

    always_comb begin
        cmp_en  = cmp_v_q && (state_q == WRITE || state_q == READ
                              || state_q == DRAIN);
        mis_a   = cmp_en && (cap_a_q != exp_val(p_q, cidx_q));
        mis_b   = cmp_en && (cap_b_q != exp_val(p_q, ~cidx_q));
        err_sum = {1'b0, err_q} + {8'd0, mis_a} + {8'd0, mis_b};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
        go_done = (state_q == DRAIN && p_q)
                  || (STOP_ON_FAIL && (mis_a || mis_b));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            k_q      <= 5'd0;
            p_q      <= 1'b0;
            test_q   <= 1'b0;
            we_q     <= 1'b0;
            wreg_q   <= 5'd0;
            ra_q     <= 5'd0;
            rb_q     <= 5'd0;
            wdata_q  <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 8'd0;
            ffreg_q  <= 5'd0;
            ffport_q <= 1'b0;
            cmp_v_q  <= 1'b0;
            cidx_q   <= 5'd0;
            cap_a_q  <= 32'd0;
            cap_b_q  <= 32'd0;
        end else begin
            cmp_v_q <= (state_q == READ);
            cidx_q  <= k_q;
            cap_a_q <= t_data_readRegA;
            cap_b_q <= t_data_readRegB;

            if (cmp_en) begin
                err_q <= err_d;
                if (err_q == 8'd0 && (mis_a || mis_b)) begin
                    ffreg_q  <= mis_a ? cidx_q : ~cidx_q;
                    ffport_q <= !mis_a;
                end
            end

            if (go_done) begin
                state_q <= DONE;
                test_q  <= 1'b0;
                we_q    <= 1'b0;
                wreg_q  <= 5'd0;
                ra_q    <= 5'd0;
                rb_q    <= 5'd0;
                wdata_q <= 32'd0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (err_d == 8'd0);
            end else begin
                unique case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q  <= WRITE;
                            k_q      <= 5'd0;
                            p_q      <= 1'b0;
                            test_q   <= 1'b1;
                            we_q     <= 1'b1;
                            wreg_q   <= 5'd0;
                            wdata_q  <= pat(1'b0, 5'd0);
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            pass_q   <= 1'b0;
                            err_q    <= 8'd0;
                            ffreg_q  <= 5'd0;
                            ffport_q <= 1'b0;
                        end
                    end
                    WRITE: begin
                        if (k_q == 5'd31) begin
                            state_q <= READ;
                            k_q     <= 5'd0;
                            we_q    <= 1'b0;
                            ra_q    <= 5'd0;
                            rb_q    <= 5'd31;
                        end else begin
                            k_q     <= k_q + 5'd1;
                            wreg_q  <= k_q + 5'd1;
                            wdata_q <= pat(p_q, k_q + 5'd1);
                        end
                    end
                    READ: begin
                        if (k_q == 5'd31) begin
                            state_q <= DRAIN;
                        end else begin
                            k_q  <= k_q + 5'd1;
                            ra_q <= k_q + 5'd1;
                            rb_q <= ~(k_q + 5'd1);
                        end
                    end
                    DRAIN: begin
                        state_q <= WRITE;
                        k_q     <= 5'd0;
                        p_q     <= 1'b1;
                        we_q    <= 1'b1;
                        wreg_q  <= 5'd0;
                        wdata_q <= pat(1'b1, 5'd0);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign test               = test_q;
    assign t_ctrl_writeEnable = we_q;
    assign t_ctrl_writeReg    = wreg_q;
    assign t_ctrl_readRegA    = ra_q;
    assign t_ctrl_readRegB    = rb_q;
    assign t_data_writeReg    = wdata_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign err_count          = err_q;
    assign first_fail_reg     = ffreg_q;
    assign first_fail_port    = ffport_q;

endmodule
